// File: rtl/audioport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audioport_pkg
//  Description : Shared command codes, status bit positions, clock-divider
//                constant and playback-sequencer types for audioport.
//  Revision    : 1.0  initial release
// ============================================================================
package audioport_pkg;

    // One-hot command words written to CMD_REG
    localparam logic [31:0] CMD_NOP    = 32'h0000_0000;
    localparam logic [31:0] CMD_CLR    = 32'h0000_0001;
    localparam logic [31:0] CMD_CFG    = 32'h0000_0002;
    localparam logic [31:0] CMD_START  = 32'h0000_0004;
    localparam logic [31:0] CMD_STOP   = 32'h0000_0008;
    localparam logic [31:0] CMD_LEVEL  = 32'h0000_0010;
    localparam logic [31:0] CMD_IRQACK = 32'h0000_0020;

    // STATUS_REG bit positions
    localparam int STATUS_PLAY   = 0;
    localparam int STATUS_NODATA = 1;

    // 100 MHz system clock / 48 kHz sample rate, rounded down
    localparam logic [31:0] CLK_DIV_48000 = 32'd2083;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_PLAY = 1'b1
    } seq_state_t;

    // True when exactly one bit of the word is set
    function automatic logic is_onehot32(input logic [31:0] w);
        return (w != 32'h0) && ((w & (w - 32'd1)) == 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Down-counting clock divider producing a one-cycle tick each
//                time the count reaches zero while enabled. Divisors below 2
//                are treated as 2. The divisor is sampled on load and reload.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_divider #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_in,
    input  logic             clear_in,
    input  logic             en_in,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick_out
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] reload_val;

    // Reload value is divisor-1, with the divisor clamped to at least 2
    always_comb begin
        reload_val = (div_in < DIV_W'(2)) ? DIV_W'(1) : (div_in - DIV_W'(1));
    end

    assign tick_out = en_in && (count_q == '0);

    // Next count: clear wins, then load, then decrement/reload while enabled
    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (load_in) begin
            count_d = reload_val;
        end else if (en_in) begin
            count_d = (count_q == '0) ? reload_val : (count_q - DIV_W'(1));
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/play_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : play_sequencer
//  Description : Playback controller for audioport. Decodes one-hot commands,
//                tracks IDLE/PLAY, generates the sample tick, pops one stereo
//                pair per tick and raises a sticky interrupt on FIFO underrun.
//                Optional underrun counter enabled by PLAY_SEQ_UCNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module play_sequencer
    import audioport_pkg::*;
#(
    parameter int DIV_W  = 32,
    parameter int UCNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_in,
    input  logic [31:0]      cmd_in,
    input  logic [DIV_W-1:0] clk_div_in,
    input  logic             fifo_empty_in,
    output logic             fifo_pop_out,
    output logic             tick_out,
    output logic             play_out,
    output logic             clr_out,
    output logic             cfg_out,
    output logic             level_out,
    output logic [31:0]      status_out,
    output logic             irq_out
);

    seq_state_t state_q, state_d;
    logic       clr_q, clr_d;
    logic       cfg_q, cfg_d;
    logic       level_q, level_d;
    logic       irq_q, irq_d;
    logic       nodata_q, nodata_d;
    logic [15:0] ucnt_field;

    logic cmd_ok;
    logic is_idle;
    logic do_start;
    logic do_stop;
    logic do_clr;
    logic tick;
    logic underrun;

    // Command decode: only single-bit words are acted upon
    always_comb begin
        cmd_ok   = cmd_valid_in && is_onehot32(cmd_in);
        is_idle  = (state_q == SEQ_IDLE);
        do_start = cmd_ok && is_idle  && (cmd_in == CMD_START);
        do_stop  = cmd_ok && !is_idle && (cmd_in == CMD_STOP);
        do_clr   = cmd_ok && is_idle  && (cmd_in == CMD_CLR);
        underrun = tick && fifo_empty_in;
    end

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_in  (do_start),
        .clear_in (do_stop),
        .en_in    (state_q == SEQ_PLAY),
        .div_in   (clk_div_in),
        .tick_out (tick)
    );

    // Next-state, pulse and sticky-flag logic
    always_comb begin
        state_d  = state_q;
        if (do_start) begin
            state_d = SEQ_PLAY;
        end else if (do_stop) begin
            state_d = SEQ_IDLE;
        end
        clr_d    = do_clr;
        cfg_d    = cmd_ok && is_idle && (cmd_in == CMD_CFG);
        level_d  = cmd_ok && is_idle && (cmd_in == CMD_LEVEL);
        nodata_d = tick ? fifo_empty_in : nodata_q;
        // A new underrun outranks a simultaneous acknowledge
        irq_d    = irq_q;
        if (underrun) begin
            irq_d = 1'b1;
        end else if (cmd_ok && (cmd_in == CMD_IRQACK)) begin
            irq_d = 1'b0;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            clr_q    <= 1'b0;
            cfg_q    <= 1'b0;
            level_q  <= 1'b0;
            irq_q    <= 1'b0;
            nodata_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            cfg_q    <= cfg_d;
            level_q  <= level_d;
            irq_q    <= irq_d;
            nodata_q <= nodata_d;
        end
    end

`ifdef PLAY_SEQ_UCNT_EN
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;

    // Saturating underrun counter, cleared by CLR while idle
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun && (ucnt_q != {UCNT_W{1'b1}})) begin
            ucnt_d = ucnt_q + UCNT_W'(1);
        end else if (do_clr) begin
            ucnt_d = '0;
        end
    end

    // Underrun counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign ucnt_field = 16'(ucnt_q);
`else
    assign ucnt_field = 16'h0000;
`endif

    // Output mapping
    always_comb begin
        status_out                = {ucnt_field, 16'h0000};
        status_out[STATUS_PLAY]   = (state_q == SEQ_PLAY);
        status_out[STATUS_NODATA] = nodata_q;
    end

    assign play_out     = (state_q == SEQ_PLAY);
    assign tick_out     = tick;
    assign fifo_pop_out = tick && !fifo_empty_in;
    assign clr_out      = clr_q;
    assign cfg_out      = cfg_q;
    assign level_out    = level_q;
    assign irq_out      = irq_q;

endmodule
`default_nettype wire
